// File: rtl/commit_unit.sv
// In-order commit stage: tracks per-tag completion from the CDB and pops the
// order queue when its oldest tag is done, with a one-cycle settle bubble per pop.
module commit_unit #(
    parameter int TAGWIDTH   = 5,
    parameter int NUMTAGS    = 32,
    parameter int COUNTWIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alloc_valid,
    input  logic [TAGWIDTH-1:0]   alloc_tag,
    input  logic                  cdb_valid,
    input  logic [TAGWIDTH-1:0]   cdb_tag,
    input  logic [TAGWIDTH-1:0]   head_tag,
    input  logic                  queue_empty,
    input  logic                  stall,
    output logic                  pop,
    output logic                  commit_valid,
    output logic [TAGWIDTH-1:0]   commit_tag,
    output logic [COUNTWIDTH-1:0] pending_count,
    output logic                  overflow
);

    typedef enum logic {READY, SETTLE} state_t;

    localparam logic [COUNTWIDTH-1:0] FULL_COUNT = COUNTWIDTH'(NUMTAGS);

    state_t              state, state_next;
    logic [NUMTAGS-1:0]  done, done_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clock) begin
        if (reset) state <= READY;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            READY:   if (pop) state_next = SETTLE;
            SETTLE:  state_next = READY;
            default: state_next = READY;
        endcase
    end

    // Pop reads only the registered done bit; a same-cycle CDB cannot bypass it.
    always_comb begin
        pop = 1'b0;
        if (!reset && state == READY)
            pop = !queue_empty && !stall && done[head_tag];
    end

    // Later assignments win: alloc clear beats pop clear beats CDB set.
    always_comb begin
        done_next = done;
        for (int i = 0; i < NUMTAGS; i++) begin
            if (cdb_valid && cdb_tag == TAGWIDTH'(i))
                done_next[i] = 1'b1;
            if (pop && head_tag == TAGWIDTH'(i))
                done_next[i] = 1'b0;
            if (alloc_valid && alloc_tag == TAGWIDTH'(i))
                done_next[i] = 1'b0;
        end
    end

    // NOTE: the done bitmap is control state, not data storage, so it is
    // reset; a stale done bit would otherwise trigger a spurious pop.
    always_ff @(posedge clock) begin
        if (reset) done <= '0;
        else       done <= done_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            commit_valid <= 1'b0;
            commit_tag   <= '0;
        end else begin
            commit_valid <= pop;
            if (pop) commit_tag <= head_tag;
        end
    end

    // Saturating occupancy; an alloc with the counter already full is an overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_count <= '0;
            overflow      <= 1'b0;
        end else begin
            case ({alloc_valid, pop})
                2'b10: begin
                    if (pending_count == FULL_COUNT) overflow <= 1'b1;
                    else pending_count <= pending_count + 1'b1;
                end
                2'b01: begin
                    if (pending_count != '0) pending_count <= pending_count - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_commit_unit.sv
// Bench for commit_unit: directed scenarios plus random traffic, checked against
// a tag-set / FIFO reference model of the commit rules.
module tb_commit_unit;

    localparam int TW = 5;
    localparam int NT = 32;
    localparam int CW = 6;

    logic          clock;
    logic          reset;
    logic          alloc_valid;
    logic [TW-1:0] alloc_tag;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [TW-1:0] head_tag;
    logic          queue_empty;
    logic          stall;
    logic          pop;
    logic          commit_valid;
    logic [TW-1:0] commit_tag;
    logic [CW-1:0] pending_count;
    logic          overflow;

    commit_unit #(.TAGWIDTH(TW), .NUMTAGS(NT), .COUNTWIDTH(CW)) dut (
        .clock         (clock),
        .reset         (reset),
        .alloc_valid   (alloc_valid),
        .alloc_tag     (alloc_tag),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .head_tag      (head_tag),
        .queue_empty   (queue_empty),
        .stall         (stall),
        .pop           (pop),
        .commit_valid  (commit_valid),
        .commit_tag    (commit_tag),
        .pending_count (pending_count),
        .overflow      (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: order queue contents, set of completed tags, counters.
    int  oq[$];
    bit  m_done[NT];
    int  m_count;
    bit  m_ovf;
    bit  m_bubble;
    bit  exp_cv;
    int  exp_ct;
    bit  keep_oq;
    bit  last_pop;
    int  seen[$];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive_head();
        queue_empty = (oq.size() == 0);
        head_tag    = (oq.size() != 0) ? TW'(oq[0]) : '0;
    endtask

    task automatic drive(input bit av, input int at, input bit cv, input int ct, input bit st);
        alloc_valid = av;
        alloc_tag   = TW'(at);
        cdb_valid   = cv;
        cdb_tag     = TW'(ct);
        stall       = st;
    endtask

    function automatic bit inflight(input int t);
        foreach (oq[i]) if (oq[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic cycle();
        bit exp_pop;
        int head;
        @(negedge clock);
        exp_pop = !reset && !m_bubble && oq.size() > 0 && !stall && m_done[oq[0]];
        last_pop = pop;
        check("pop", {31'd0, pop}, {31'd0, exp_pop});
        @(posedge clock);
        head = (oq.size() != 0) ? oq[0] : 0;
        if (reset) begin
            foreach (m_done[i]) m_done[i] = 1'b0;
            m_count  = 0;
            m_ovf    = 1'b0;
            m_bubble = 1'b0;
            exp_cv   = 1'b0;
            exp_ct   = 0;
            if (!keep_oq) oq.delete();
        end else begin
            if (cdb_valid)   m_done[cdb_tag] = 1'b1;
            if (exp_pop)     m_done[head] = 1'b0;
            if (alloc_valid) m_done[alloc_tag] = 1'b0;
            if (alloc_valid && !exp_pop) begin
                if (m_count == NT) m_ovf = 1'b1;
                else m_count++;
            end else if (!alloc_valid && exp_pop && m_count > 0) begin
                m_count--;
            end
            exp_cv   = exp_pop;
            if (exp_pop) exp_ct = head;
            m_bubble = exp_pop;
            if (exp_pop) void'(oq.pop_front());
            if (alloc_valid && oq.size() < NT) oq.push_back(int'(alloc_tag));
        end
        #1;
        check("commit_valid", {31'd0, commit_valid}, {31'd0, exp_cv});
        check("commit_tag", {27'd0, commit_tag}, exp_ct);
        check("pending_count", {26'd0, pending_count}, m_count);
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (commit_valid) seen.push_back(int'(commit_tag));
        drive_head();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        keep_oq  = 1'b0;
        m_count  = 0;
        m_ovf    = 1'b0;
        m_bubble = 1'b0;
        exp_cv   = 1'b0;
        exp_ct   = 0;
        foreach (m_done[i]) m_done[i] = 1'b0;
        drive(0, 0, 0, 0, 0);
        drive_head();

        // Reset state
        cycle();
        do_reset();

        // Single commit: allocate 3, 7; complete 3
        drive(1, 3, 0, 0, 0); cycle();
        drive(1, 7, 0, 0, 0); cycle();
        drive(0, 0, 1, 3, 0); cycle();
        drive(0, 0, 0, 0, 0); cycle();
        check("t1_pop_after_cdb", {31'd0, last_pop}, 32'd1);
        check("t1_commit_valid", {31'd0, commit_valid}, 32'd1);
        check("t1_commit_tag", {27'd0, commit_tag}, 32'd3);
        check("t1_pending", {26'd0, pending_count}, 32'd1);
        cycle();
        drive(0, 0, 1, 7, 0); cycle();
        drive(0, 0, 0, 0, 0); cycle(); cycle();

        // Out-of-order completion commits in order
        seen.delete();
        drive(1, 4, 0, 0, 0); cycle();
        drive(1, 9, 0, 0, 0); cycle();
        drive(0, 0, 1, 9, 0); cycle();
        drive(0, 0, 0, 0, 0); cycle(); cycle(); cycle();
        check("t2_no_pop_before_4", {31'd0, last_pop}, 32'd0);
        drive(0, 0, 1, 4, 0); cycle();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle();
        check("t2_commits", seen.size(), 32'd2);
        if (seen.size() == 2) begin
            check("t2_first", seen[0], 32'd4);
            check("t2_second", seen[1], 32'd9);
        end

        // Stall holds a ready head
        drive(1, 5, 0, 0, 0); cycle();
        drive(0, 0, 1, 5, 1); cycle();
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t3_stalled", {31'd0, last_pop}, 32'd0);
        end
        drive(0, 0, 0, 0, 0); cycle();
        check("t3_pop_after_stall", {31'd0, last_pop}, 32'd1);
        cycle(); cycle();

        // Fill to capacity then overflow
        do_reset();
        for (int t = 0; t < NT; t++) begin
            drive(1, t, 0, 0, 0); cycle();
        end
        check("t4_full", {26'd0, pending_count}, 32'd32);
        check("t4_no_ovf_yet", {31'd0, overflow}, 32'd0);
        drive(1, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 0); cycle(); cycle();
        check("t4_ovf_sticky", {31'd0, overflow}, 32'd1);
        check("t4_count_sat", {26'd0, pending_count}, 32'd32);

        // Same-cycle alloc and CDB on one tag: alloc wins
        do_reset();
        drive(1, 6, 1, 6, 0); cycle();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t5_no_pop", {31'd0, last_pop}, 32'd0);
        end
        drive(0, 0, 1, 6, 0); cycle();
        drive(0, 0, 0, 0, 0); cycle();
        check("t5_pop_after_cdb", {31'd0, last_pop}, 32'd1);
        cycle();

        // Reset during SETTLE with a commit pending
        do_reset();
        drive(1, 2, 0, 0, 0); cycle();
        drive(1, 8, 0, 0, 0); cycle();
        drive(0, 0, 1, 2, 0); cycle();
        drive(0, 0, 1, 8, 0); cycle();
        check("t6_commit_pending", {31'd0, commit_valid}, 32'd1);
        keep_oq = 1'b1;
        reset   = 1'b1;
        drive(0, 0, 0, 0, 0); cycle();
        reset   = 1'b0;
        keep_oq = 1'b0;
        check("t6_cv_dropped", {31'd0, commit_valid}, 32'd0);
        check("t6_count_zero", {26'd0, pending_count}, 32'd0);
        cycle();
        check("t6_no_stale_pop", {31'd0, last_pop}, 32'd0);
        cycle();
        check("t6_no_stale_pop2", {31'd0, last_pop}, 32'd0);
        oq.delete();
        drive_head();

        // Random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit av, cv, st;
            int at, ct;
            int cand[$];
            av = 1'b0; cv = 1'b0; at = 0; ct = 0;
            st = ($urandom_range(9) < 2);
            if ($urandom_range(9) < 4) begin
                cand.delete();
                for (int t = 0; t < NT; t++) if (!inflight(t)) cand.push_back(t);
                if (cand.size() != 0) begin
                    av = 1'b1;
                    at = cand[$urandom_range(cand.size() - 1)];
                end else if ($urandom_range(19) == 0) begin
                    av = 1'b1;
                    at = $urandom_range(NT - 1);
                end
            end
            if ($urandom_range(9) < 4) begin
                cv = 1'b1;
                if (oq.size() != 0 && $urandom_range(9) != 0)
                    ct = oq[$urandom_range(oq.size() - 1)];
                else
                    ct = $urandom_range(NT - 1);
            end
            reset = ($urandom_range(399) == 0);
            drive(av, at, cv, ct, st);
            cycle();
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        cycle(); cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
